// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style pipeline: opcodes, ALU operations and the
// ID/EX control bundle produced by the main decoder.
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_HLT   = 6'b000101;
    localparam logic [5:0] OP_MUL   = 6'b000110;
    localparam logic [5:0] OP_LW    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b001000;
    localparam logic [5:0] OP_ADDI  = 6'b001001;
    localparam logic [5:0] OP_SUBI  = 6'b001010;
    localparam logic [5:0] OP_SLTI  = 6'b001011;
    localparam logic [5:0] OP_BNEQZ = 6'b001100;
    localparam logic [5:0] OP_BEQZ  = 6'b001101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef struct packed {
        logic       halt;
        logic       branch;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       branch_nz;
    } ctrl_t;

endpackage : mips_pkg

// File: rtl/alu_control_unit.sv
// ID-stage main decoder: combinational opcode -> control mapping, plus a
// sticky halted flag and a one-cycle-delayed illegal-opcode status.
module alu_control_unit
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int AOW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    output logic           Halt,
    output logic           Branch,
    output logic           RegWrite,
    output logic           ALUsrc,
    output logic [AOW-1:0] alu_op,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemToReg,
    output logic           RegDst,
    output logic           BranchNZ,
    output logic           halted,
    output logic           illegal
);

    ctrl_t dec;
    ctrl_t ctrl;
    logic  halted_q, halted_d;
    logic  illegal_q, illegal_d;

    // NOTE: every field gets a default before the case, so no path leaves a
    // field unassigned and no latch is inferred; unassigned opcodes fall out as a NOP.
    always_comb begin
        dec       = '0;
        illegal_d = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                unique case (opcode)
                    OP_SUB:  dec.alu_op = ALU_SUB;
                    OP_AND:  dec.alu_op = ALU_AND;
                    OP_OR:   dec.alu_op = ALU_OR;
                    OP_SLT:  dec.alu_op = ALU_SLT;
                    OP_MUL:  dec.alu_op = ALU_MUL;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_SLTI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                unique case (opcode)
                    OP_SUBI: dec.alu_op = ALU_SUB;
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQZ, OP_BNEQZ: begin
                dec.branch    = 1'b1;
                dec.branch_nz = (opcode == OP_BNEQZ);
                dec.alu_op    = ALU_SUB;
            end
            OP_HLT: dec.halt = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // Once halted, suppress every architectural side effect of later instructions.
    always_comb begin
        ctrl = dec;
        if (halted_q) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
        end
    end

    assign halted_d = halted_q | (opcode == OP_HLT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign Halt     = ctrl.halt;
    assign Branch   = ctrl.branch;
    assign RegWrite = ctrl.reg_write;
    assign ALUsrc   = ctrl.alu_src;
    assign alu_op   = ctrl.alu_op;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign MemToReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign BranchNZ = ctrl.branch_nz;
    assign halted   = halted_q;
    assign illegal  = illegal_q;

endmodule : alu_control_unit

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: decode table, halted gating and the
// registered halted/illegal status, all against hand-computed vectors.
module tb_alu_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       Halt, Branch, RegWrite, ALUsrc, MemRead, MemWrite, MemToReg, RegDst, BranchNZ;
    logic [2:0] alu_op;
    logic       halted, illegal;
    logic [11:0] ctl;

    int n_assert = 0;
    int n_fail   = 0;

    alu_control_unit #(.OPW(6), .AOW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .Halt     (Halt),
        .Branch   (Branch),
        .RegWrite (RegWrite),
        .ALUsrc   (ALUsrc),
        .alu_op   (alu_op),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemToReg (MemToReg),
        .RegDst   (RegDst),
        .BranchNZ (BranchNZ),
        .halted   (halted),
        .illegal  (illegal)
    );

    // Field order: Halt Branch RegWrite ALUsrc alu_op[2:0] MemRead MemWrite MemToReg RegDst BranchNZ
    assign ctl = {Halt, Branch, RegWrite, ALUsrc, alu_op, MemRead, MemWrite, MemToReg, RegDst, BranchNZ};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input string tag, input logic [5:0] op, input logic [11:0] exp);
        opcode = op;
        #1;
        check(tag, ctl, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        tick();
        tick();
        check("reset_halted",  {11'd0, halted},  12'd0);
        check("reset_illegal", {11'd0, illegal}, 12'd0);
        decode("reset_add_comb", 6'b000000, 12'b0_0_1_0_000_0_0_0_1_0);
        rst_n = 1'b1;

        decode("add",   6'b000000, 12'b0_0_1_0_000_0_0_0_1_0);
        decode("sub",   6'b000001, 12'b0_0_1_0_001_0_0_0_1_0);
        decode("and",   6'b000010, 12'b0_0_1_0_010_0_0_0_1_0);
        decode("or",    6'b000011, 12'b0_0_1_0_011_0_0_0_1_0);
        decode("slt",   6'b000100, 12'b0_0_1_0_100_0_0_0_1_0);
        decode("mul",   6'b000110, 12'b0_0_1_0_101_0_0_0_1_0);
        decode("lw",    6'b000111, 12'b0_0_1_1_000_1_0_1_0_0);
        decode("sw",    6'b001000, 12'b0_0_0_1_000_0_1_0_0_0);
        decode("addi",  6'b001001, 12'b0_0_1_1_000_0_0_0_0_0);
        decode("subi",  6'b001010, 12'b0_0_1_1_001_0_0_0_0_0);
        decode("slti",  6'b001011, 12'b0_0_1_1_100_0_0_0_0_0);
        decode("bneqz", 6'b001100, 12'b0_1_0_0_001_0_0_0_0_1);
        decode("beqz",  6'b001101, 12'b0_1_0_0_001_0_0_0_0_0);
        tick();
        check("illegal_after_valid", {11'd0, illegal}, 12'd0);
        check("halted_still_clear",  {11'd0, halted},  12'd0);

        decode("unassigned_3f", 6'b111111, 12'd0);
        tick();
        check("illegal_set_3f", {11'd0, illegal}, 12'd1);
        decode("unassigned_0e", 6'b001110, 12'd0);
        tick();
        check("illegal_held_0e", {11'd0, illegal}, 12'd1);
        opcode = 6'b000000;
        tick();
        check("illegal_cleared", {11'd0, illegal}, 12'd0);

        opcode = 6'b111111;
        tick();
        check("illegal_set_again", {11'd0, illegal}, 12'd1);
        rst_n = 1'b0;
        tick();
        check("illegal_reset", {11'd0, illegal}, 12'd0);
        rst_n = 1'b1;

        decode("hlt_comb", 6'b000101, 12'b1_0_0_0_000_0_0_0_0_0);
        check("halted_before_edge", {11'd0, halted}, 12'd0);
        tick();
        check("halted_set", {11'd0, halted}, 12'd1);
        check("hlt_not_illegal", {11'd0, illegal}, 12'd0);
        decode("halted_add",   6'b000000, 12'b0_0_0_0_000_0_0_0_1_0);
        decode("halted_sw",    6'b001000, 12'b0_0_0_1_000_0_0_0_0_0);
        decode("halted_lw",    6'b000111, 12'b0_0_0_1_000_1_0_1_0_0);
        decode("halted_bneqz", 6'b001100, 12'b0_0_0_0_001_0_0_0_0_1);
        decode("halted_hlt",   6'b000101, 12'b1_0_0_0_000_0_0_0_0_0);
        opcode = 6'b000000;
        tick();
        tick();
        check("halted_sticky", {11'd0, halted}, 12'd1);

        rst_n  = 1'b0;
        opcode = 6'b000101;
        tick();
        check("reset_beats_hlt", {11'd0, halted}, 12'd0);
        decode("hlt_in_reset_comb", 6'b000101, 12'b1_0_0_0_000_0_0_0_0_0);
        rst_n = 1'b1;
        decode("add_after_reset", 6'b000000, 12'b0_0_1_0_000_0_0_0_1_0);
        tick();
        check("halted_clear_after_reset", {11'd0, halted}, 12'd0);
        decode("sw_after_reset", 6'b001000, 12'b0_0_0_1_000_0_1_0_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_alu_control_unit
